beta_dmem_lsu_port: RTL and testbench
=====================================

// Module: beta_dmem_lsu_port
// PURPOSE
//  Load/store port between the execution stage and the data memory bus.
//  Replaces the single-transaction RDMEM/WDMEM handshake FSMs with one parametrised port:
//  - configurable bus width
//  - up to MAX_OUTST outstanding transactions, with a metadata FIFO
//  - byte-enable generation, and load alignment plus sign/zero extension
//  Sits between exe-stage control (mem_op/mem_op_size) and the dmem bus.
// PARAMETERS
//  DATA_W     32  bus data width; legal values 32 or 64; OFS_W = log2(DATA_W/8)
//  ADDR_W     32  byte address width
//  MAX_OUTST  2   max accepted transactions without a response (1..8); metadata FIFO depth
// PORTS
//  clk_i             in   1         clock
//  rst_i             in   1         asynchronous reset, active-high
//  req_valid_i       in   1         exe request valid
//  req_ready_o       out  1         port accepts request this cycle
//  req_op_i          in   1         0 = load (MEM_LOAD_OP), 1 = store (MEM_STORE_OP)
//  req_size_i        in   2         01 = word, 10 = half, 11 = byte; 00 is illegal
//  req_unsigned_i    in   1         1 = zero-extend load; 0 = sign-extend
//  req_addr_i        in   ADDR_W    byte address
//  req_wdata_i       in   32        store data, LSB-aligned
//  rsp_valid_o       out  1         response valid (one-cycle pulse)
//  rsp_rdata_o       out  32        extended load data; 0 for stores
//  rsp_err_o         out  1         misaligned-access error, with rsp_valid_o
//  dmem_valid_o      out  1         bus request valid
//  dmem_ready_i      in   1         bus accepts request
//  dmem_we_o         out  1         bus write enable
//  dmem_addr_o       out  ADDR_W    bus address, aligned to DATA_W/8
//  dmem_be_o         out  DATA_W/8  byte enables
//  dmem_wdata_o      out  DATA_W    lane-replicated store data
//  dmem_rvalid_i     in   1         bus response valid (loads and stores, in order)
//  dmem_rdata_i      in   DATA_W    bus read data
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM in IDLE, FIFO empty, outstanding count = 0.
//  - Request FSM, 2 states:
//    - IDLE: req_ready_o = !fifo_full.
//      On req_valid_i && req_ready_o, register the bus fields, push metadata to the FIFO,
//      and go to WRDY with dmem_valid_o = 1.
//    - WRDY: dmem_valid_o = 1; bus fields are held stable; req_ready_o = 0.
//      On dmem_ready_i, go to IDLE. Issue latency is 1 cycle from acceptance.
//    - Back-to-back: in WRDY with dmem_ready_i = 1, req_ready_o is still 0.
//      Peak rate is 1 request per 2 cycles.
//  - Metadata entry: {op, size, unsigned, addr[OFS_W-1:0], err}.
//    Count increments on push, decrements on pop. Push and pop in the same cycle leave the count unchanged.
//  - fifo_full (count == MAX_OUTST) blocks acceptance; a same-cycle pop does not unblock.
//  - Byte enables for offset o = addr[OFS_W-1:0]:
//    - word: 4'hF << o
//    - half: 2'b11 << o
//    - byte: 1 << o
//  - Store data: word replicated across DATA_W/32 lanes; half ×(DATA_W/16); byte ×(DATA_W/8).
//  - dmem_addr_o = addr with its low OFS_W bits cleared.
//  - Load data: dmem_rdata_i >> (8*o), truncated to the size.
//    Sign-extended from bit 7/15 unless unsigned; words pass through unchanged.
//  - Response: on dmem_rvalid_i, pop the FIFO head.
//    rsp_valid_o pulses in the same cycle (combinational from dmem_rdata_i and the head).
//  - dmem_rvalid_i with an empty FIFO is ignored (no pulse, count stays 0).
//  - Illegal size 00: treated as a word access.
//  - Reset mid-operation: the FSM, FIFO and count clear immediately; late bus responses are ignored (FIFO empty).
// CONFIGURATION
//  BETA_DMEM_MISALIGN_TRAP_EN
//   defined:
//    - Misaligned if: word with addr[1:0] != 0, or half with addr[0] != 0.
//    - A misaligned request is accepted but not issued on the bus; no entry is pushed to the FIFO.
//    - Next cycle: rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
//    - If a bus response pops in that same cycle, the error response is delayed one cycle.
//   undefined:
//    - rsp_err_o is tied to 0.
//    - Misaligned accesses are issued with the shifted byte enables; enables past the bus width are dropped.
// TESTING
//  1. Load byte, signed:
//     addr 0x1003, DATA_W=32, rdata 0x80AABBCC -> be 4'b1000, dmem_addr 0x1000, rsp_rdata 0xFFFFFF80.
//  2. Load half, unsigned:
//     addr 0x2002, rdata 0x8001_1234 -> be 4'b1100, rsp_rdata 0x00008001.
//  3. Store byte:
//     addr 0x3001, wdata 0x000000A5 -> dmem_wdata 0xA5A5A5A5, be 4'b0010, we 1; ack -> rsp_rdata 0.
//  4. Outstanding limit, MAX_OUTST=2:
//     3 loads with dmem_ready_i = 1 and no rvalid -> third held, req_ready_o = 0.
//     One rvalid -> 3rd accepted the next cycle; responses return in order.
//  5. Stall:
//     dmem_ready_i = 0 for 5 cycles -> dmem_valid_o and addr/be/wdata stable for all 5 cycles.
//  6. Misalign (BETA_DMEM_MISALIGN_TRAP_EN defined):
//     word load at 0x4002 -> no dmem_valid_o; rsp_err_o = 1 the next cycle.
//     Also: rst_i asserted in WRDY -> dmem_valid_o = 0 immediately, count = 0.

Source files
------------

// File: rtl/beta_dmem_lsu_port.sv
// Exe-stage load/store port to the dmem bus, up to MAX_OUTST in flight; optional trap via BETA_DMEM_MISALIGN_TRAP_EN.
// Issue 1 cycle after accept, response same cycle as dmem_rvalid_i; req_ready_o low while issuing or MAX_OUTST pending.
module beta_dmem_lsu_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_op_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [31:0]         req_wdata_i,
    output logic                rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                dmem_valid_o,
    input  logic                dmem_ready_i,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [DATA_W/8-1:0] dmem_be_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    input  logic                dmem_rvalid_i,
    input  logic [DATA_W-1:0]   dmem_rdata_i
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WRDY = 1'b1
    } state_t;

    typedef struct packed {
        logic             op;
        logic [1:0]       size;
        logic             uns;
        logic [OFS_W-1:0] ofs;
        logic             err;
    } meta_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_dmem_valid;

    logic               r_dmem_we;
    logic [ADDR_W-1:0]  r_dmem_addr;
    logic [BE_W-1:0]    r_dmem_be;
    logic [DATA_W-1:0]  r_dmem_wdata;

    meta_t              r_fifo [MAX_OUTST];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic [OFS_W-1:0]   w_req_ofs;
    logic               w_is_word;
    logic               w_is_half;
    logic [BE_W-1:0]    w_be_base;
    logic [BE_W-1:0]    w_req_be;
    logic [DATA_W-1:0]  w_req_wdata;
    logic [ADDR_W-1:0]  w_req_addr;
    logic               w_full;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_err_block;
    logic               w_err_rsp;
    meta_t              w_push_meta;
    meta_t              w_head;
    logic [31:0]        w_shifted;
    logic [31:0]        w_ld_data;

    // ---------------- request decode ----------------
    assign w_req_ofs  = req_addr_i[OFS_W-1:0];
    assign w_is_word  = (req_size_i == 2'b01) || (req_size_i == 2'b00);
    assign w_is_half  = (req_size_i == 2'b10);
    assign w_req_addr = {req_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    always_comb begin
        w_be_base   = BE_W'(1'b1);
        w_req_wdata = {(DATA_W/8){req_wdata_i[7:0]}};
        if (w_is_word) begin
            w_be_base   = BE_W'(4'hF);
            w_req_wdata = {(DATA_W/32){req_wdata_i}};
        end else if (w_is_half) begin
            w_be_base   = BE_W'(2'b11);
            w_req_wdata = {(DATA_W/16){req_wdata_i[15:0]}};
        end
    end

    // Lanes shifted past the bus width fall off the top.
    assign w_req_be = w_be_base << w_req_ofs;

    assign w_full      = (r_count == CNT_W'(MAX_OUTST));
    assign req_ready_o = !rst_i && (r_state == ST_IDLE) && !w_full && !w_err_block;
    assign w_accept    = req_valid_i && req_ready_o;

`ifdef BETA_DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_err_pend;

    assign w_misalign  = (w_is_word && (req_addr_i[1:0] != 2'b00)) ||
                         (w_is_half && req_addr_i[0]);
    assign w_push      = w_accept && !w_misalign;
    assign w_err_block = r_err_pend;
    // A bus response owns the response slot; the trap waits until it is free.
    assign w_err_rsp   = r_err_pend && !w_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_pend <= 1'b0;
        end else if (w_accept && w_misalign) begin
            r_err_pend <= 1'b1;
        end else if (!w_pop) begin
            r_err_pend <= 1'b0;
        end
    end
`else
    assign w_push      = w_accept;
    assign w_err_block = 1'b0;
    assign w_err_rsp   = 1'b0;
`endif

    // ---------------- request FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dmem_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_WRDY;
                end
            end
            ST_WRDY: begin
                w_dmem_valid = 1'b1;
                if (dmem_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
        end else if (w_push) begin
            r_dmem_we    <= req_op_i;
            r_dmem_addr  <= w_req_addr;
            r_dmem_be    <= w_req_be;
            r_dmem_wdata <= w_req_wdata;
        end
    end

    assign dmem_valid_o = w_dmem_valid;
    assign dmem_we_o    = r_dmem_we;
    assign dmem_addr_o  = r_dmem_addr;
    assign dmem_be_o    = r_dmem_be;
    assign dmem_wdata_o = r_dmem_wdata;

    // ---------------- metadata FIFO ----------------
    assign w_push_meta = '{op: req_op_i, size: req_size_i, uns: req_unsigned_i,
                           ofs: w_req_ofs, err: 1'b0};
    assign w_pop  = dmem_rvalid_i && (r_count != '0);
    assign w_head = r_fifo[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(MAX_OUTST - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(MAX_OUTST - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // ---------------- load alignment and extension ----------------
    assign w_shifted = 32'(dmem_rdata_i >> {w_head.ofs, 3'b000});

    always_comb begin
        w_ld_data = w_shifted;
        if (w_head.size == 2'b10) begin
            w_ld_data = {{16{!w_head.uns && w_shifted[15]}}, w_shifted[15:0]};
        end else if (w_head.size == 2'b11) begin
            w_ld_data = {{24{!w_head.uns && w_shifted[7]}}, w_shifted[7:0]};
        end
    end

    assign rsp_valid_o = w_pop || w_err_rsp;
    assign rsp_rdata_o = (w_pop && !w_head.op) ? w_ld_data : 32'h0;
    assign rsp_err_o   = w_pop ? w_head.err : w_err_rsp;

endmodule

// File: tb/tb_beta_dmem_lsu_port.sv
`timescale 1ns/1ps
// Bench for beta_dmem_lsu_port at DATA_W=32, MAX_OUTST=2: vector table, corner sequences, random vs. model.
module tb_beta_dmem_lsu_port;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_op_i = 1'b0;
    logic [1:0]    req_size_i = 2'b01;
    logic          req_unsigned_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          dmem_valid_o;
    logic          dmem_ready_i = 1'b0;
    logic          dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [DW/8-1:0] dmem_be_o;
    logic [DW-1:0] dmem_wdata_o;
    logic          dmem_rvalid_i = 1'b0;
    logic [DW-1:0] dmem_rdata_i = '0;

    beta_dmem_lsu_port #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTST(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .dmem_valid_o(dmem_valid_o), .dmem_ready_i(dmem_ready_i),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_daddr;
        logic [31:0] exp_dwdata;
        logic [31:0] exp_rsp;
    } vec_t;

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rtx_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input logic op, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid_i    = 1'b1;
        req_op_i       = op;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
    endtask

    // ---------------- reference model (byte-level view) ----------------
    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b10) ? 2 : (sz == 2'b11) ? 1 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes_of(sz);
        int o = int'(a % 4);
        logic [3:0] be = '0;
        for (int b = 0; b < 4; b++) if (b >= o && b < o + n) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes_of(sz);
        logic [31:0] r = '0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes_of(sz);
        int o = int'(a % 4);
        longint v = 0;
        for (int k = 0; k < n; k++)
            if (o + k < 4) v += longint'((rd >> (8*(o+k))) & 32'hFF) << (8*k);
        if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    // ---------------- single transaction from the vector table ----------------
    task automatic run_vec(input vec_t v, input int idx);
        set_req(v.op, v.size, v.uns, v.addr, v.wdata);
        settle();
        chk($sformatf("v%0d req_ready", idx), req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk($sformatf("v%0d dmem_valid", idx), dmem_valid_o, 1);
        chk($sformatf("v%0d dmem_addr", idx), dmem_addr_o, v.exp_daddr);
        chk($sformatf("v%0d dmem_be", idx), dmem_be_o, v.exp_be);
        chk($sformatf("v%0d dmem_we", idx), dmem_we_o, v.op);
        if (v.op) chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata_o, v.exp_dwdata);
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        settle();
        chk($sformatf("v%0d dmem_valid_drop", idx), dmem_valid_o, 0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = v.rdata;
        settle();
        chk($sformatf("v%0d rsp_valid", idx), rsp_valid_o, 1);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata_o, v.exp_rsp);
        chk($sformatf("v%0d rsp_err", idx), rsp_err_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;
        settle();
        chk($sformatf("v%0d rsp_pulse_end", idx), rsp_valid_o, 0);
    endtask

    vec_t vt[$];
    rtx_t q[$];

    initial begin
        // Vector table: op, size, uns, addr, wdata, rdata, be, dmem_addr, dmem_wdata, rsp_rdata
        vt.push_back('{0, 2'b11, 0, 32'h1003, 32'h0, 32'h80AABBCC, 4'b1000, 32'h1000, 32'h0, 32'hFFFFFF80});
        vt.push_back('{0, 2'b10, 1, 32'h2002, 32'h0, 32'h80011234, 4'b1100, 32'h2000, 32'h0, 32'h00008001});
        vt.push_back('{1, 2'b11, 0, 32'h3001, 32'hA5, 32'h12345678, 4'b0010, 32'h3000, 32'hA5A5A5A5, 32'h0});
        vt.push_back('{0, 2'b01, 0, 32'h5000, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h5000, 32'h0, 32'hDEADBEEF});
        vt.push_back('{0, 2'b10, 0, 32'h6000, 32'h0, 32'h12348765, 4'b0011, 32'h6000, 32'h0, 32'hFFFF8765});
        vt.push_back('{0, 2'b11, 1, 32'h7002, 32'h0, 32'h11F23344, 4'b0100, 32'h7000, 32'h0, 32'h000000F2});
        vt.push_back('{1, 2'b10, 0, 32'h8002, 32'hFFFFBEEF, 32'h0, 4'b1100, 32'h8000, 32'hBEEFBEEF, 32'h0});
        vt.push_back('{1, 2'b01, 0, 32'h9004, 32'h12345678, 32'h0, 4'b1111, 32'h9004, 32'h12345678, 32'h0});
        vt.push_back('{0, 2'b00, 0, 32'hA000, 32'h0, 32'hCAFEF00D, 4'b1111, 32'hA000, 32'h0, 32'hCAFEF00D});
`ifndef BETA_DMEM_MISALIGN_TRAP_EN
        vt.push_back('{0, 2'b01, 0, 32'hB002, 32'h0, 32'hAABBCCDD, 4'b1100, 32'hB000, 32'h0, 32'h0000AABB});
        vt.push_back('{0, 2'b10, 0, 32'hC003, 32'h0, 32'h9A000000, 4'b1000, 32'hC000, 32'h0, 32'h0000009A});
`endif

        // Reset state
        tick();
        settle();
        chk("rst req_ready", req_ready_o, 0);
        chk("rst dmem_valid", dmem_valid_o, 0);
        chk("rst dmem_we", dmem_we_o, 0);
        chk("rst dmem_addr", dmem_addr_o, 0);
        chk("rst dmem_be", dmem_be_o, 0);
        chk("rst dmem_wdata", dmem_wdata_o, 0);
        chk("rst rsp_valid", rsp_valid_o, 0);
        chk("rst rsp_rdata", rsp_rdata_o, 0);
        chk("rst rsp_err", rsp_err_o, 0);
        tick();
        rst_i = 1'b0;
        settle();
        chk("post-rst req_ready", req_ready_o, 1);

        foreach (vt[i]) run_vec(vt[i], i);

        // Outstanding limit and in-order responses
        tick();
        dmem_ready_i = 1'b1;
        set_req(0, 2'b01, 0, 32'h100, 0);
        settle();
        chk("lim A ready", req_ready_o, 1);
        tick();
        set_req(0, 2'b11, 0, 32'h105, 0);
        settle();
        chk("lim b2b valid", dmem_valid_o, 1);
        chk("lim b2b ready", req_ready_o, 0);
        tick();
        settle();
        chk("lim B ready", req_ready_o, 1);
        tick();
        set_req(0, 2'b10, 1, 32'h10A, 0);
        settle();
        chk("lim B addr", dmem_addr_o, 32'h104);
        tick();
        settle();
        chk("lim full ready", req_ready_o, 0);
        tick();
        settle();
        chk("lim full ready2", req_ready_o, 0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80818283;
        settle();
        chk("lim rspA valid", rsp_valid_o, 1);
        chk("lim rspA data", rsp_rdata_o, ref_load(2'b01, 0, 32'h100, 32'h80818283));
        chk("lim pop no unblock", req_ready_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;
        settle();
        chk("lim C ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("lim C addr", dmem_addr_o, 32'h108);
        tick();
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b1;
        settle();
        chk("lim rspB data", rsp_rdata_o, 32'hFFFFFF82);
        tick();
        settle();
        chk("lim rspC data", rsp_rdata_o, 32'h00008081);
        tick();
        dmem_rvalid_i = 1'b0;
        settle();
        chk("lim drained", rsp_valid_o, 0);

        // Bus stall: fields held
        set_req(1, 2'b11, 0, 32'h3001, 32'h000000A5);
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("stall%0d valid", c), dmem_valid_o, 1);
            chk($sformatf("stall%0d addr", c), dmem_addr_o, 32'h3000);
            chk($sformatf("stall%0d be", c), dmem_be_o, 4'b0010);
            chk($sformatf("stall%0d wdata", c), dmem_wdata_o, 32'hA5A5A5A5);
            chk($sformatf("stall%0d ready", c), req_ready_o, 0);
            tick();
        end
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFFFFFF;
        settle();
        chk("stall rsp valid", rsp_valid_o, 1);
        chk("stall rsp rdata", rsp_rdata_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;

        // Response with empty FIFO is ignored
        dmem_rvalid_i = 1'b1;
        settle();
        chk("spurious rsp_valid", rsp_valid_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;

        // Reset while waiting for the bus
        set_req(0, 2'b01, 0, 32'h200, 0);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("rstmid valid pre", dmem_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rstmid valid", dmem_valid_o, 0);
        chk("rstmid ready", req_ready_o, 0);
        tick();
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        settle();
        chk("rstmid late rsp", rsp_valid_o, 0);
        chk("rstmid ready after", req_ready_o, 1);
        tick();
        dmem_rvalid_i = 1'b0;

`ifdef BETA_DMEM_MISALIGN_TRAP_EN
        set_req(0, 2'b01, 0, 32'h4002, 0);
        settle();
        chk("trap ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        settle();
        chk("trap no issue", dmem_valid_o, 0);
        chk("trap rsp_valid", rsp_valid_o, 1);
        chk("trap rsp_err", rsp_err_o, 1);
        chk("trap rsp_rdata", rsp_rdata_o, 0);
        tick();
        settle();
        chk("trap pulse end", rsp_valid_o, 0);
        set_req(0, 2'b01, 0, 32'h300, 0);
        tick();
        req_valid_i  = 1'b0;
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        set_req(0, 2'b01, 0, 32'h4006, 0);
        settle();
        chk("trap2 ready", req_ready_o, 1);
        tick();
        req_valid_i   = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5A5A0001;
        settle();
        chk("trap2 bus rsp", rsp_rdata_o, 32'h5A5A0001);
        chk("trap2 bus err", rsp_err_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;
        settle();
        chk("trap2 delayed valid", rsp_valid_o, 1);
        chk("trap2 delayed err", rsp_err_o, 1);
        tick();
`endif

        // Randomized traffic against the transaction-level model
        begin
            bit   busy = 1'b0;
            int   bus_pend = 0;
            rtx_t t;
            bit   exp_rdy, acc, hs, rv;
            for (int cyc = 0; cyc < 600; cyc++) begin
                t.op    = 1'($urandom_range(0, 1));
                t.size  = 2'($urandom_range(0, 3));
                t.uns   = 1'($urandom_range(0, 1));
                t.addr  = $urandom;
                t.wdata = $urandom;
`ifdef BETA_DMEM_MISALIGN_TRAP_EN
                t.addr = t.addr & ~(32'(nbytes_of(t.size)) - 32'd1);
`endif
                set_req(t.op, t.size, t.uns, t.addr, t.wdata);
                req_valid_i   = 1'($urandom_range(0, 1));
                dmem_ready_i  = ($urandom_range(0, 2) != 0);
                rv            = (bus_pend > 0) && ($urandom_range(0, 2) != 0);
                dmem_rvalid_i = rv;
                dmem_rdata_i  = $urandom;
                settle();
                exp_rdy = !busy && (q.size() < MO);
                chk("rnd req_ready", req_ready_o, exp_rdy);
                chk("rnd dmem_valid", dmem_valid_o, busy);
                if (busy) begin
                    chk("rnd dmem_addr", dmem_addr_o, q[q.size()-1].addr & ~32'h3);
                    chk("rnd dmem_be", dmem_be_o, ref_be(q[q.size()-1].size, q[q.size()-1].addr));
                    chk("rnd dmem_we", dmem_we_o, q[q.size()-1].op);
                    if (q[q.size()-1].op)
                        chk("rnd dmem_wdata", dmem_wdata_o,
                            ref_wdata(q[q.size()-1].size, q[q.size()-1].wdata));
                end
                chk("rnd rsp_valid", rsp_valid_o, rv);
                if (rv) begin
                    chk("rnd rsp_rdata", rsp_rdata_o, q[0].op ? 32'h0 :
                        ref_load(q[0].size, q[0].uns, q[0].addr, dmem_rdata_i));
                    chk("rnd rsp_err", rsp_err_o, 0);
                end
                acc = req_valid_i && exp_rdy;
                hs  = busy && dmem_ready_i;
                if (rv) begin
                    void'(q.pop_front());
                    bus_pend--;
                end
                if (hs) begin
                    busy = 1'b0;
                    bus_pend++;
                end
                if (acc) begin
                    q.push_back(t);
                    busy = 1'b1;
                end
                tick();
            end
            req_valid_i   = 1'b0;
            dmem_rvalid_i = 1'b0;
            dmem_ready_i  = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
